// File: rtl/optical_frame_sampler_if.sv
// Bundles the receiver's enable/line input and its byte/status outputs.
// The sampler connects through the slave modport; the driver side uses master.
interface optical_frame_sampler_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 enable;
  logic                 rx_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;
  logic                 sample_tick;

  modport master (
    output enable,
    output rx_in,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy,
    input  sample_tick
  );

  modport slave (
    input  enable,
    input  rx_in,
    output data_out,
    output data_valid,
    output frame_err,
    output busy,
    output sample_tick
  );
endinterface

// File: rtl/optical_frame_sampler.sv
// Phase-aligned receive sampler: start-edge detect, mid-bit sampling, byte assembly.
// Optional MAJORITY_VOTE_EN: 2-of-3 vote around each mid-bit sample, decision one cycle later.
module optical_frame_sampler #(
  parameter int unsigned CLKS_PER_BIT = 54,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          IDLE_LEVEL   = 1'b1
) (
  input logic                    clock,
  input logic                    reset,
  optical_frame_sampler_if.slave bus
);

`ifdef MAJORITY_VOTE_EN
  localparam int unsigned Lag = 1;
`else
  localparam int unsigned Lag = 0;
`endif

  localparam int unsigned PhaseW = $clog2(CLKS_PER_BIT + Lag);
  localparam int unsigned BitW   = $clog2(DATA_BITS + 1);

  localparam logic [PhaseW-1:0] StartThr    = PhaseW'(CLKS_PER_BIT / 2 - 1 + Lag);
  localparam logic [PhaseW-1:0] BitThr      = PhaseW'(CLKS_PER_BIT - 1 + Lag);
  localparam logic [PhaseW-1:0] PhaseReload = PhaseW'(Lag);
  localparam logic [BitW-1:0]   LastBit     = BitW'(DATA_BITS - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [PhaseW-1:0]    phase_q, phase_d;
  logic [BitW-1:0]      bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 tick_q, tick_d;
  logic [DATA_BITS:0]   shift_ext;

  logic sync1_q, rx_s_q, rx_d_q;
  logic samp_bit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= IDLE_LEVEL;
      rx_s_q  <= IDLE_LEVEL;
      rx_d_q  <= IDLE_LEVEL;
    end else begin
      sync1_q <= bus.rx_in;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

`ifdef MAJORITY_VOTE_EN
  // rx_dd/rx_d/rx_s hold the line at phases mid-1, mid, mid+1 when the decision fires.
  logic rx_dd_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rx_dd_q <= IDLE_LEVEL;
    else        rx_dd_q <= rx_d_q;
  end
  assign samp_bit = (rx_dd_q & rx_d_q) | (rx_dd_q & rx_s_q) | (rx_d_q & rx_s_q);
`else
  assign samp_bit = rx_s_q;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    tick_d    = 1'b0;
    shift_ext = {samp_bit, shift_q};

    if (!bus.enable) begin
      // Abandon any frame in flight; the partial shift register is never published.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_d_q == IDLE_LEVEL && rx_s_q == ~IDLE_LEVEL) begin
            state_d = StStart;
            phase_d = '0;
          end
        end
        StStart: begin
          if (phase_q == StartThr) begin
            tick_d = 1'b1;
            if (samp_bit == ~IDLE_LEVEL) begin
              state_d  = StData;
              phase_d  = PhaseReload;
              bitcnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
        StData: begin
          if (phase_q == BitThr) begin
            tick_d   = 1'b1;
            shift_d  = shift_ext[DATA_BITS:1];
            bitcnt_d = bitcnt_q + BitW'(1);
            phase_d  = PhaseReload;
            if (bitcnt_q == LastBit) state_d = StStop;
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
        StStop: begin
          if (phase_q == BitThr) begin
            tick_d  = 1'b1;
            state_d = StIdle;
            phase_d = '0;
            if (samp_bit == IDLE_LEVEL) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_err   = ferr_q;
  assign bus.sample_tick = tick_q;
  assign bus.busy        = (state_q != StIdle);

  valid_err_exclusive: assert property (@(posedge clock) disable iff (!reset)
    !(valid_q && ferr_q));

endmodule
